// File: rtl/ex_arb_pkg.sv
// ============================================================================
// Module   : ex_arb_pkg
// Brief    : Shared states, request struct and width defaults for ex_port_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ex_arb_pkg;

  localparam int ARB_ADDR_WID   = 14;
  localparam int ARB_DATA_WID   = 32;
  localparam int ARB_BYTE_SHIFT = 2;
  localparam int HOST_WID       = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_ISSUE0 = 3'd2,
    ST_WAIT0  = 3'd3,
    ST_ISSUE1 = 3'd4,
    ST_WAIT1  = 3'd5,
    ST_FINISH = 3'd6
  } arb_state_e;

  typedef struct packed {
    logic                    we;
    logic [ARB_ADDR_WID-1:0] addr;
    logic [ARB_DATA_WID-1:0] d;
  } arb_req_t;

  function automatic logic [HOST_WID-1:0] host_addr(
    input logic [HOST_WID-1:0]     base,
    input logic [ARB_ADDR_WID-1:0] addr,
    input int unsigned             shift
  );
    return base + ({{(HOST_WID-ARB_ADDR_WID){1'b0}}, addr} << shift);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_port_capture.sv
// ============================================================================
// Module   : ex_port_capture
// Brief    : One pending-request slot; clear has priority over capture.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_port_capture
  import ex_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     cap_i,
  input  logic     clr_i,
  input  arb_req_t req_i,
  output logic     valid_o,
  output arb_req_t req_o
);

  logic     valid_q;
  arb_req_t req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else if (cap_i) begin
      valid_q <= 1'b1;
      req_q   <= req_i;
    end
  end

  assign valid_o = valid_q;
  assign req_o   = req_q;

endmodule

`default_nettype wire

// File: rtl/ex_port_arbiter.sv
// ============================================================================
// Module   : ex_port_arbiter
// Brief    : Freezes an HLS kernel (clock enable) while its two ex ports are
//            serviced, port 0 first, over one host read/write handshake.
//            Optional statistics counters: define ACCESS_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_port_arbiter
  import ex_arb_pkg::*;
#(
  parameter int ADDR_WID   = ARB_ADDR_WID,
  parameter int DATA_WID   = ARB_DATA_WID,
  parameter int BYTE_SHIFT = ARB_BYTE_SHIFT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  output logic                done_o,
  output logic                kern_start_o,
  input  logic                kern_done_i,
  output logic                kern_ce_o,
  input  logic                p0_ce_i,
  input  logic                p0_we_i,
  input  logic [ADDR_WID-1:0] p0_addr_i,
  input  logic [DATA_WID-1:0] p0_d_i,
  output logic [DATA_WID-1:0] p0_q_o,
  input  logic                p1_ce_i,
  input  logic                p1_we_i,
  input  logic [ADDR_WID-1:0] p1_addr_i,
  input  logic [DATA_WID-1:0] p1_d_i,
  output logic [DATA_WID-1:0] p1_q_o,
  input  logic [63:0]         read_base_i,
  input  logic [63:0]         write_base_i,
  input  logic [63:0]         xfer_size_i,
  output logic                rd_req_o,
  output logic [63:0]         rd_addr_o,
  output logic [63:0]         rd_size_o,
  input  logic                rd_ready_i,
  input  logic [DATA_WID-1:0] rd_data_i,
  output logic                wr_req_o,
  output logic [63:0]         wr_addr_o,
  output logic [63:0]         wr_size_o,
  output logic [DATA_WID-1:0] wr_data_o,
  input  logic                wr_ready_i,
  output logic [63:0]         access_cnt_o,
  output logic [63:0]         stall_cnt_o
);

  arb_state_e          state_q, state_d;
  logic                kern_start_q, kern_start_d;
  logic                done_q, done_d;
  logic                done_lat_q, done_lat_d;
  logic [DATA_WID-1:0] p0_q_q, p0_q_d, p1_q_q, p1_q_d;
  logic [63:0]         rd_addr_q, rd_size_q, wr_addr_q, wr_size_q;
  logic [DATA_WID-1:0] wr_data_q;
  logic                cap0, cap1, clr0, clr1, valid0, valid1;
  logic                ready0, ready1, issuing;
  arb_req_t            live0, live1, slot0, slot1, iss;
  logic [63:0]         iss_rd_addr, iss_wr_addr;

  assign live0 = '{we: p0_we_i, addr: ARB_ADDR_WID'(p0_addr_i), d: ARB_DATA_WID'(p0_d_i)};
  assign live1 = '{we: p1_we_i, addr: ARB_ADDR_WID'(p1_addr_i), d: ARB_DATA_WID'(p1_d_i)};

  ex_port_capture u_slot0 (
    .clk(clk), .rst_n(rst_n), .cap_i(cap0), .clr_i(clr0),
    .req_i(live0), .valid_o(valid0), .req_o(slot0)
  );

  ex_port_capture u_slot1 (
    .clk(clk), .rst_n(rst_n), .cap_i(cap1), .clr_i(clr1),
    .req_i(live1), .valid_o(valid1), .req_o(slot1)
  );

  // A ready only counts when it matches the direction of the slot being waited on.
  assign ready0 = valid0 && (slot0.we ? wr_ready_i : rd_ready_i);
  assign ready1 = valid1 && (slot1.we ? wr_ready_i : rd_ready_i);

  assign issuing     = (state_q == ST_ISSUE0) || (state_q == ST_ISSUE1);
  assign iss         = (state_q == ST_ISSUE1) ? slot1 : slot0;
  assign iss_rd_addr = host_addr(read_base_i, iss.addr, BYTE_SHIFT);
  assign iss_wr_addr = host_addr(write_base_i, iss.addr, BYTE_SHIFT);

  assign rd_req_o  = issuing && !iss.we;
  assign wr_req_o  = issuing && iss.we;
  assign rd_addr_o = rd_req_o ? iss_rd_addr : rd_addr_q;
  assign rd_size_o = rd_req_o ? xfer_size_i : rd_size_q;
  assign wr_addr_o = wr_req_o ? iss_wr_addr : wr_addr_q;
  assign wr_size_o = wr_req_o ? xfer_size_i : wr_size_q;
  assign wr_data_o = wr_req_o ? DATA_WID'(iss.d) : wr_data_q;

  assign kern_ce_o    = (state_q == ST_RUN);
  assign kern_start_o = kern_start_q;
  assign done_o       = done_q;
  assign p0_q_o       = p0_q_q;
  assign p1_q_o       = p1_q_q;

  always_comb begin
    state_d      = state_q;
    kern_start_d = kern_start_q;
    done_lat_d   = done_lat_q;
    done_d       = 1'b0;
    p0_q_d       = p0_q_q;
    p1_q_d       = p1_q_q;
    cap0         = 1'b0;
    cap1         = 1'b0;
    clr0         = 1'b0;
    clr1         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d      = ST_RUN;
          kern_start_d = 1'b1;
        end
      end
      ST_RUN: begin
        cap0 = p0_ce_i;
        cap1 = p1_ce_i;
        if (kern_done_i && (p0_ce_i || p1_ce_i)) done_lat_d = 1'b1;
        if (p0_ce_i)          state_d = ST_ISSUE0;
        else if (p1_ce_i)     state_d = ST_ISSUE1;
        else if (kern_done_i) state_d = ST_FINISH;
      end
      ST_ISSUE0: state_d = ST_WAIT0;
      ST_ISSUE1: state_d = ST_WAIT1;
      ST_WAIT0: begin
        if (ready0) begin
          clr0 = 1'b1;
          if (!slot0.we) p0_q_d = rd_data_i;
          if (valid1)          state_d = ST_ISSUE1;
          else if (done_lat_q) state_d = ST_FINISH;
          else                 state_d = ST_RUN;
        end
      end
      ST_WAIT1: begin
        if (ready1) begin
          clr1 = 1'b1;
          if (!slot1.we) p1_q_d = rd_data_i;
          state_d = done_lat_q ? ST_FINISH : ST_RUN;
        end
      end
      ST_FINISH: begin
        clr0       = 1'b1;
        clr1       = 1'b1;
        done_lat_d = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_FINISH) begin
      done_d       = 1'b1;
      kern_start_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      kern_start_q <= 1'b0;
      done_q       <= 1'b0;
      done_lat_q   <= 1'b0;
      p0_q_q       <= '0;
      p1_q_q       <= '0;
      rd_addr_q    <= '0;
      rd_size_q    <= '0;
      wr_addr_q    <= '0;
      wr_size_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      kern_start_q <= kern_start_d;
      done_q       <= done_d;
      done_lat_q   <= done_lat_d;
      p0_q_q       <= p0_q_d;
      p1_q_q       <= p1_q_d;
      if (rd_req_o) begin
        rd_addr_q <= iss_rd_addr;
        rd_size_q <= xfer_size_i;
      end
      if (wr_req_o) begin
        wr_addr_q <= iss_wr_addr;
        wr_size_q <= xfer_size_i;
        wr_data_q <= DATA_WID'(iss.d);
      end
    end
  end

`ifdef ACCESS_CNT_EN
  logic [63:0] access_cnt_q, stall_cnt_q;
  logic        serviced;

  assign serviced = ((state_q == ST_WAIT0) && ready0) || ((state_q == ST_WAIT1) && ready1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      access_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else if ((state_q == ST_IDLE) && start_i) begin
      access_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (serviced && (access_cnt_q != '1)) access_cnt_q <= access_cnt_q + 64'd1;
      if (kern_start_q && !kern_ce_o && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 64'd1;
    end
  end

  assign access_cnt_o = access_cnt_q;
  assign stall_cnt_o  = stall_cnt_q;
`else
  assign access_cnt_o = '0;
  assign stall_cnt_o  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_port_arbiter.sv
// ============================================================================
// Module   : tb_ex_port_arbiter
// Brief    : Scoreboard bench for ex_port_arbiter with an inline host responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ex_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 0, kern_done_i = 0;
  logic        done_o, kern_start_o, kern_ce_o;
  logic        p0_ce_i = 0, p0_we_i = 0, p1_ce_i = 0, p1_we_i = 0;
  logic [13:0] p0_addr_i = 0, p1_addr_i = 0;
  logic [31:0] p0_d_i = 0, p1_d_i = 0, p0_q_o, p1_q_o;
  logic [63:0] read_base_i = 0, write_base_i = 0, xfer_size_i = 64'h40;
  logic        rd_req_o, wr_req_o, rd_ready_i = 0, wr_ready_i = 0;
  logic [63:0] rd_addr_o, rd_size_o, wr_addr_o, wr_size_o;
  logic [31:0] rd_data_i = 0, wr_data_o;
  logic [63:0] access_cnt_o, stall_cnt_o;

  always #5 clk = ~clk;

  ex_port_arbiter dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .done_o(done_o),
    .kern_start_o(kern_start_o), .kern_done_i(kern_done_i), .kern_ce_o(kern_ce_o),
    .p0_ce_i(p0_ce_i), .p0_we_i(p0_we_i), .p0_addr_i(p0_addr_i), .p0_d_i(p0_d_i), .p0_q_o(p0_q_o),
    .p1_ce_i(p1_ce_i), .p1_we_i(p1_we_i), .p1_addr_i(p1_addr_i), .p1_d_i(p1_d_i), .p1_q_o(p1_q_o),
    .read_base_i(read_base_i), .write_base_i(write_base_i), .xfer_size_i(xfer_size_i),
    .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_size_o(rd_size_o),
    .rd_ready_i(rd_ready_i), .rd_data_i(rd_data_i),
    .wr_req_o(wr_req_o), .wr_addr_o(wr_addr_o), .wr_size_o(wr_size_o),
    .wr_data_o(wr_data_o), .wr_ready_i(wr_ready_i),
    .access_cnt_o(access_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  typedef struct {
    bit          we;
    logic [63:0] addr;
    logic [31:0] data;
    logic [63:0] size;
  } exp_req_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_req_t    exp_req[$];
  logic [31:0] exp_q0[$], exp_q1[$];
  logic [31:0] hmem[logic [63:0]];
  logic [31:0] model[logic [63:0]];

  function automatic logic [31:0] init_val(input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] host_rd(input logic [63:0] a);
    return hmem.exists(a) ? hmem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] model_rd(input logic [63:0] a);
    return model.exists(a) ? model[a] : init_val(a);
  endfunction

  task automatic push_port(input bit ce, input bit we, input int port,
                           input logic [13:0] a, input logic [31:0] d);
    exp_req_t e;
    if (!ce) return;
    e.we   = we;
    e.size = xfer_size_i;
    if (!we) begin
      e.addr = read_base_i + 64'(a) * 64'd4;
      e.data = '0;
      if (port == 0) exp_q0.push_back(model_rd(e.addr));
      else           exp_q1.push_back(model_rd(e.addr));
    end else begin
      e.addr = write_base_i + 64'(a) * 64'd4;
      e.data = d;
      model[e.addr] = d;
    end
    exp_req.push_back(e);
  endtask

  // One kernel step: present requests for one RUN cycle, act as host until the
  // kernel is enabled again (or the kernel has finished), return stall length.
  task automatic kern_step(input bit p0ce, input bit p0we, input logic [13:0] p0a, input logic [31:0] p0d,
                           input bit p1ce, input bit p1we, input logic [13:0] p1a, input logic [31:0] p1d,
                           input bit kdone, input int dly, input bit wrong,
                           output int low, output int dones);
    int          cnt;
    bit          cur_we, fin;
    logic [63:0] cur_addr;
    exp_req_t    e;
    push_port(p0ce, p0we, 0, p0a, p0d);
    push_port(p1ce, p1we, 1, p1a, p1d);
    p0_ce_i = p0ce; p0_we_i = p0we; p0_addr_i = p0a; p0_d_i = p0d;
    p1_ce_i = p1ce; p1_we_i = p1we; p1_addr_i = p1a; p1_d_i = p1d;
    kern_done_i = kdone;
    @(posedge clk); #1;
    p0_ce_i = 0; p1_ce_i = 0; kern_done_i = 0;
    low = 0; dones = 0; cnt = 0; fin = 0; cur_we = 0; cur_addr = '0;
    while (kern_ce_o !== 1'b1 && low < 200 && !fin) begin
      rd_ready_i = 0; wr_ready_i = 0;
      if (done_o) dones++;
      if (rd_req_o || wr_req_o) begin
        n_tests++;
        if (exp_req.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_req: rd_req=%0b wr_req=%0b, expected none", rd_req_o, wr_req_o);
        end else begin
          e = exp_req.pop_front();
          if ((rd_req_o && wr_req_o) || (wr_req_o !== e.we) ||
              ((e.we ? wr_addr_o : rd_addr_o) !== e.addr) ||
              ((e.we ? wr_size_o : rd_size_o) !== e.size) ||
              (e.we && (wr_data_o !== e.data))) begin
            n_fail++;
            $display("FAIL req: rd=%0b wr=%0b raddr=%h waddr=%h wdata=%h, expected we=%0b addr=%h data=%h size=%h",
                     rd_req_o, wr_req_o, rd_addr_o, wr_addr_o, wr_data_o, e.we, e.addr, e.data, e.size);
          end
        end
        cnt      = dly;
        cur_we   = wr_req_o;
        cur_addr = wr_req_o ? wr_addr_o : rd_addr_o;
        if (wr_req_o) hmem[wr_addr_o] = wr_data_o;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          if (cur_we) wr_ready_i = 1;
          else begin
            rd_ready_i = 1;
            rd_data_i  = host_rd(cur_addr);
          end
        end else if (wrong) begin
          if (cur_we) begin
            rd_ready_i = 1;
            rd_data_i  = 32'hBADB_AD00;
          end else wr_ready_i = 1;
        end
      end
      low++;
      @(posedge clk); #1;
      if (dones > 0 && !done_o && !kern_start_o) fin = 1;
    end
    rd_ready_i = 0; wr_ready_i = 0;
    n_tests++;
    if (low >= 200 || exp_req.size() != 0) begin
      n_fail++;
      $display("FAIL step_complete: stall=%0d pending=%0d, expected <200 and 0", low, exp_req.size());
      exp_req.delete();
    end
    if (p0ce && !p0we) begin
      n_tests++;
      e.data = exp_q0.pop_front();
      if (p0_q_o !== e.data) begin
        n_fail++;
        $display("FAIL p0_q: got %h expected %h", p0_q_o, e.data);
      end
    end
    if (p1ce && !p1we) begin
      n_tests++;
      e.data = exp_q1.pop_front();
      if (p1_q_o !== e.data) begin
        n_fail++;
        $display("FAIL p1_q: got %h expected %h", p1_q_o, e.data);
      end
    end
  endtask

  task automatic check_low(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: kern_ce low %0d cycles, expected %0d", name, got, exp);
    end
  endtask

  task automatic do_start;
    start_i = 1;
    @(posedge clk); #1;
    start_i = 0;
    n_tests++;
    if (kern_start_o !== 1'b1 || kern_ce_o !== 1'b1 || access_cnt_o !== 64'd0 || stall_cnt_o !== 64'd0) begin
      n_fail++;
      $display("FAIL start: kern_start=%0b kern_ce=%0b acc=%0d stall=%0d, expected 1 1 0 0",
               kern_start_o, kern_ce_o, access_cnt_o, stall_cnt_o);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({kern_ce_o, kern_start_o, done_o, rd_req_o, wr_req_o} !== 5'b0 ||
        p0_q_o !== 32'd0 || rd_addr_o !== 64'd0 || access_cnt_o !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_state: ce=%0b start=%0b done=%0b rd=%0b wr=%0b q=%h, expected all 0",
               kern_ce_o, kern_start_o, done_o, rd_req_o, wr_req_o, p0_q_o);
    end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read;
    int low, dn;
    read_base_i = 64'h1000;
    hmem[64'h1040]  = 32'hDEAD_BEEF;
    model[64'h1040] = 32'hDEAD_BEEF;
    do_start();
    kern_step(1, 0, 14'h10, 0, 0, 0, 0, 0, 0, 1, 0, low, dn);
    check_low("single_read", low, 2);
    kern_step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, low, dn);
    check_low("no_access", low, 0);
    n_tests++;
    if (p0_q_o !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL q_hold: got %h expected deadbeef", p0_q_o);
    end
  endtask

  task automatic test_same_addr;
    int low, dn;
    read_base_i  = 64'h2000;
    write_base_i = 64'h2000;
    kern_step(1, 0, 14'd5, 0, 1, 1, 14'd5, 32'd7, 0, 1, 0, low, dn);
    check_low("rd_then_wr", low, 4);
    kern_step(0, 0, 0, 0, 1, 0, 14'd5, 0, 0, 1, 0, low, dn);
    check_low("p1_read", low, 2);
    kern_step(1, 1, 14'd9, 32'h11, 1, 1, 14'd9, 32'h22, 0, 1, 0, low, dn);
    check_low("two_writes", low, 4);
    kern_step(1, 0, 14'd9, 0, 0, 0, 0, 0, 0, 2, 0, low, dn);
    check_low("read_after_writes", low, 3);
  endtask

  task automatic test_stall;
    int low, dn;
    logic [63:0] s0, a0, s_exp, a_exp;
    s0 = stall_cnt_o;
    a0 = access_cnt_o;
    kern_step(0, 0, 0, 0, 1, 1, 14'd3, 32'hCAFE_0003, 0, 10, 0, low, dn);
    check_low("slow_write", low, 11);
`ifdef ACCESS_CNT_EN
    s_exp = s0 + 64'd11;
    a_exp = a0 + 64'd1;
`else
    s_exp = 64'd0;
    a_exp = 64'd0;
`endif
    n_tests++;
    if (stall_cnt_o !== s_exp || access_cnt_o !== a_exp) begin
      n_fail++;
      $display("FAIL counters: stall=%0d acc=%0d, expected %0d %0d", stall_cnt_o, access_cnt_o, s_exp, a_exp);
    end
  endtask

  task automatic test_spurious;
    int low, dn;
    logic [31:0] q0;
    q0 = p0_q_o;
    rd_ready_i = 1;
    rd_data_i  = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    rd_ready_i = 0;
    n_tests++;
    if (kern_ce_o !== 1'b1 || p0_q_o !== q0) begin
      n_fail++;
      $display("FAIL spurious_run: ce=%0b q=%h, expected 1 %h", kern_ce_o, p0_q_o, q0);
    end
    kern_step(1, 0, 14'h21, 0, 0, 0, 0, 0, 0, 3, 1, low, dn);
    check_low("wrong_dir_ready", low, 4);
  endtask

  task automatic test_done;
    int low, dn;
    kern_step(1, 0, 14'h30, 0, 0, 0, 0, 0, 1, 1, 0, low, dn);
    check_low("done_with_ce", low, 3);
    n_tests++;
    if (dn !== 1 || kern_start_o !== 1'b0 || kern_ce_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL done_ce: pulses=%0d start=%0b ce=%0b, expected 1 0 0", dn, kern_start_o, kern_ce_o);
    end
    do_start();
    kern_step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, low, dn);
    check_low("done_only", low, 1);
    n_tests++;
    if (dn !== 1 || kern_start_o !== 1'b0) begin
      n_fail++;
      $display("FAIL done_only: pulses=%0d start=%0b, expected 1 0", dn, kern_start_o);
    end
  endtask

  task automatic test_reset_mid_wait;
    int low, dn;
    do_start();
    read_base_i = 64'h3000;
    p0_ce_i = 1; p0_we_i = 0; p0_addr_i = 14'd2;
    @(posedge clk); #1;
    p0_ce_i = 0;
    n_tests++;
    if (rd_req_o !== 1'b1 || rd_addr_o !== 64'h3008) begin
      n_fail++;
      $display("FAIL pre_reset_req: rd_req=%0b addr=%h, expected 1 3008", rd_req_o, rd_addr_o);
    end
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    n_tests++;
    if ({kern_ce_o, kern_start_o, done_o, rd_req_o, wr_req_o} !== 5'b0 ||
        rd_addr_o !== 64'd0 || rd_size_o !== 64'd0 || p0_q_o !== 32'd0 || stall_cnt_o !== 64'd0) begin
      n_fail++;
      $display("FAIL async_reset: ce=%0b start=%0b rd=%0b addr=%h q=%h, expected all 0",
               kern_ce_o, kern_start_o, rd_req_o, rd_addr_o, p0_q_o);
    end
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    rd_ready_i = 1;
    rd_data_i  = 32'h1234_5678;
    @(posedge clk); #1;
    rd_ready_i = 0;
    n_tests++;
    if (kern_ce_o !== 1'b0 || kern_start_o !== 1'b0 || p0_q_o !== 32'd0) begin
      n_fail++;
      $display("FAIL late_ready: ce=%0b start=%0b q=%h, expected 0 0 0", kern_ce_o, kern_start_o, p0_q_o);
    end
    do_start();
    kern_step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, low, dn);
    check_low("post_reset_finish", low, 1);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_same_addr();
    test_stall();
    test_spurious();
    test_done();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
